pulse_width_decoder: RTL and testbench
======================================

Name: pulse_width_decoder

Overview:
Receive-side counterpart of the pulse stretcher. It measures the high time of an incoming stretched pulse in clk cycles and recovers the value that encoded it, so a stretcher driven with delay_value = D decodes back to D. The result goes out on a single-entry valid/ready output register, with overflow, glitch-filter and overrun reporting. It sits on the receive path, in the same clk domain as the stretcher.

Parameters:
CNT_W, 4, width of the decoded value and width counter
MAX_WIDTH, 15, largest legal width in cycles; must be <= 2**CNT_W-1
MIN_WIDTH, 1, widths below this are dropped silently as glitches; must be >= 1 and <= MAX_WIDTH

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
en  input  1  decoder enable; low forces state ARM and aborts any measurement
pulse_in  input  1  stretched pulse; synchronous to clk
out_value  output  CNT_W  decoded width in cycles
out_err  output  1  qualifies out_value; set when the pulse exceeded MAX_WIDTH
out_valid  output  1  out_value/out_err hold a result not yet taken
out_ready  input  1  consumer accepts the result when out_valid && out_ready at posedge
overrun  output  1  sticky flag: a completed result was dropped because the slot was full
clr_overrun  input  1  synchronous clear of overrun; has priority over a same-cycle set

Behaviour:
- Reset values: state=ARM, cnt=0, pulse_q=0, out_value=0, out_err=0, out_valid=0, overrun=0.
- pulse_q is pulse_in registered every cycle. rise = pulse_in & ~pulse_q; fall = ~pulse_in & pulse_q.
- ARM: waits for pulse_in sampled 0 with en=1, then goes to IDLE. This stops a pulse already high at reset or at enable from being partially measured.
- IDLE: on rise goes to MEAS and sets cnt=1.
- MEAS, each posedge:
  - pulse_in=1 and cnt<MAX_WIDTH: cnt+1.
  - pulse_in=1 and cnt==MAX_WIDTH: go to OVF; cnt holds.
  - pulse_in=0: complete with value=cnt, err=0, then go to IDLE.
- OVF: on pulse_in=0, complete with value=MAX_WIDTH, err=1, then go to IDLE.
- Counter never wraps.
- A width of N high-sampled cycles decodes to N.
- Completion latency: out_valid rises on the same posedge that first samples pulse_in=0. A stretcher pulse that is high for D cycles therefore gives out_valid exactly one cycle after pulse_out falls.
- Glitch filter: a non-error completion with value<MIN_WIDTH is discarded. It causes no output change and no overrun.
- Output slot, at each posedge:
  - If out_valid && out_ready, the slot empties.
  - A completion loads the slot when it is empty or emptying this same edge, including simultaneous accept and complete with no overrun.
  - A completion when out_valid=1 and out_ready=0 is dropped. The slot keeps the old result and overrun is set.
  - out_value/out_err stay stable while out_valid=1.
- en=0 at any time: state goes to ARM and cnt clears. The output slot and overrun are unaffected, so an in-flight pulse is lost with no report.
- Back-to-back pulses: one low cycle between pulses is enough. The cycle that completes pulse k can never be the rise of pulse k+1, because it samples low, so the next rise comes one edge later.
- Asynchronous reset mid-measurement returns to the reset values immediately. The first action after release is ARM.

Decomposition:
- Shared package pulse_pkg holds:
  - typedef enum logic [1:0] {ARM, IDLE, MEAS, OVF} pwd_state_t.
  - Default constants PULSE_CNT_W=4 and PULSE_MAX_WIDTH=15, also used by the stretcher for delay_value width.
- One sub-module: pulse_edge_detect (clk, rstn, d → d_q, rise, fall), reusable by the stretcher.

Test Plan:
- Round trip: stretcher driven with delay_value=5 feeds pulse_in, out_ready=1 → one out_valid with out_value=5, out_err=0, one cycle after the stretched pulse falls. Sweep D=1..15 → each decodes to D.
- Overflow: pulse_in held high 20 cycles with MAX_WIDTH=15 → state OVF; on the fall, out_value=15, out_err=1.
- Glitch: MIN_WIDTH=3, pulses of width 2 then 4 → only out_value=4 appears.
- Backpressure: out_ready=0, pulses of width 6 then 9 → out_value stays 6, overrun=1. Then out_ready=1 → 6 accepted, slot empty. Then clr_overrun=1 → overrun=0.
- Simultaneous: out_valid=1 holding 3, out_ready=1 on the edge completing a width-7 pulse → 3 accepted, out_value=7, out_valid stays 1, overrun stays 0.
- Partial/reset: pulse_in high during rstn release, or en rising mid-pulse → that pulse produces no output. Next width-4 pulse → 4. rstn asserted mid-MEAS → all outputs 0 immediately.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse stretcher / pulse width decoder pair.
//   pwd_state_t     : decoder FSM states
//   PULSE_CNT_W     : default width of delay/decoded values
//   PULSE_MAX_WIDTH : default largest legal pulse width in cycles
package pulse_pkg;

    localparam int unsigned PULSE_CNT_W     = 4;
    localparam int unsigned PULSE_MAX_WIDTH = 15;

    typedef enum logic [1:0] {ARM, IDLE, MEAS, OVF} pwd_state_t;

endpackage

// File: rtl/pulse_width_decoder_if.sv
// Result channel of the pulse width decoder: single-entry valid/ready slot.
//   out_value : decoded width in cycles
//   out_err   : out_value saturated because the pulse was too long
//   out_valid : slot holds a result not yet taken
//   out_ready : consumer takes the result at posedge when out_valid is set
// master = decoder side, slave = consumer side.
interface pulse_width_decoder_if #(
    parameter int unsigned CNT_W = 4
);
    logic [CNT_W-1:0] out_value;
    logic             out_err;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_value, output out_err, output out_valid, input out_ready);
    modport slave  (input out_value, input out_err, input out_valid, output out_ready);
endinterface

// File: rtl/pulse_edge_detect.sv
// Registers a level and reports its rising/falling edges.
//   clk, rstn : clock, asynchronous active-low reset
//   d         : level input, synchronous to clk
//   d_q       : d delayed by one cycle
//   rise/fall : d & ~d_q / ~d & d_q
module pulse_edge_detect (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic d_q,
    output logic rise,
    output logic fall
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;
    assign fall = ~d & d_q;

endmodule

// File: rtl/pulse_width_decoder.sv
// Measures the high time of a stretched pulse in clk cycles and returns it on a
// single-entry valid/ready slot. Pulses longer than MAX_WIDTH saturate with
// out_err set; error-free widths below MIN_WIDTH are dropped as glitches.
//   clk, rstn   : clock, asynchronous active-low reset
//   en          : low forces ARM and aborts any measurement
//   pulse_in    : stretched pulse, synchronous to clk
//   out_if      : result slot (value, err, valid / ready)
//   overrun     : sticky, a kept result was dropped because the slot was full
//   clr_overrun : synchronous clear of overrun, wins over a same-cycle set
// Widths must satisfy MAX_WIDTH <= 2**CNT_W-1 and 1 <= MIN_WIDTH <= MAX_WIDTH.
module pulse_width_decoder
    import pulse_pkg::*;
#(
    parameter int unsigned CNT_W     = PULSE_CNT_W,
    parameter int unsigned MAX_WIDTH = PULSE_MAX_WIDTH,
    parameter int unsigned MIN_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  pulse_in,
    pulse_width_decoder_if.master out_if,
    output logic                  overrun,
    input  logic                  clr_overrun
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_WIDTH);
    localparam logic [CNT_W-1:0] MinCnt = CNT_W'(MIN_WIDTH);

    pwd_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] value_q, value_d;
    logic             err_q, err_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    logic             unused_pulse_q;
    logic             rise, fall;
    logic             done, done_err, keep, accept;
    logic [CNT_W-1:0] done_value;

    // Only the edges are needed: inside MEAS/OVF the registered level is always 1.
    pulse_edge_detect u_edge (
        .clk  (clk),
        .rstn (rstn),
        .d    (pulse_in),
        .d_q  (unused_pulse_q),
        .rise (rise),
        .fall (fall)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done       = 1'b0;
        done_value = cnt_q;
        done_err   = 1'b0;
        case (state_q)
            // A pulse already high when armed must not be measured partially.
            ARM:  if (!pulse_in) state_d = IDLE;
            IDLE: if (rise) begin
                state_d = MEAS;
                cnt_d   = CNT_W'(1);
            end
            MEAS: if (fall) begin
                done    = 1'b1;
                state_d = IDLE;
            end else if (cnt_q == MaxCnt) begin
                state_d = OVF;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            OVF:  if (fall) begin
                done       = 1'b1;
                done_value = MaxCnt;
                done_err   = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = ARM;
        endcase
        if (!en) begin
            state_d = ARM;
            cnt_d   = '0;
            done    = 1'b0;
        end
    end

    // Result slot: a kept completion loads when the slot is empty or emptying.
    always_comb begin
        keep      = done && (done_err || (done_value >= MinCnt));
        accept    = valid_q && out_if.out_ready;
        valid_d   = valid_q && !accept;
        value_d   = value_q;
        err_d     = err_q;
        overrun_d = overrun_q;
        if (keep) begin
            if (!valid_q || out_if.out_ready) begin
                valid_d = 1'b1;
                value_d = done_value;
                err_d   = done_err;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (clr_overrun) overrun_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ARM;
            cnt_q     <= '0;
            value_q   <= '0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            value_q   <= value_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_if.out_value = value_q;
    assign out_if.out_err   = err_q;
    assign out_if.out_valid = valid_q;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_pulse_width_decoder.sv
module tb_pulse_width_decoder;

    localparam int MAXW = 15;
    localparam int MINW [2] = '{1, 3};

    logic clk = 1'b0;
    logic rstn, en, pulse_in, ready, clr_overrun;
    logic ovr_a, ovr_b;

    always #5 clk = ~clk;

    pulse_width_decoder_if #(.CNT_W(4)) if_a ();
    pulse_width_decoder_if #(.CNT_W(4)) if_b ();

    assign if_a.out_ready = ready;
    assign if_b.out_ready = ready;

    pulse_width_decoder #(.CNT_W(4), .MAX_WIDTH(15), .MIN_WIDTH(1)) dut_a (
        .clk         (clk),
        .rstn        (rstn),
        .en          (en),
        .pulse_in    (pulse_in),
        .out_if      (if_a),
        .overrun     (ovr_a),
        .clr_overrun (clr_overrun)
    );

    pulse_width_decoder #(.CNT_W(4), .MAX_WIDTH(15), .MIN_WIDTH(3)) dut_b (
        .clk         (clk),
        .rstn        (rstn),
        .en          (en),
        .pulse_in    (pulse_in),
        .out_if      (if_b),
        .overrun     (ovr_b),
        .clr_overrun (clr_overrun)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // Behavioural model: counts consecutive high samples of a pulse whose rise
    // was seen after the input was observed low while enabled.
    bit mprev;
    bit marmed [2];
    bit mmeas  [2];
    int mwidth [2];
    bit mvalid [2];
    int mval   [2];
    bit merr   [2];
    bit movr   [2];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mprev = 1'b0;
            for (int k = 0; k < 2; k++) begin
                marmed[k] = 0; mmeas[k] = 0; mwidth[k] = 0;
                mvalid[k] = 0; mval[k] = 0; merr[k] = 0; movr[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                automatic bit done = 0;
                automatic int v = 0;
                automatic bit e = 0;
                automatic bit keep;
                automatic bit acc = mvalid[k] && ready;
                if (!en) begin
                    marmed[k] = 0;
                    mmeas[k]  = 0;
                end else if (!marmed[k]) begin
                    if (!pulse_in) marmed[k] = 1;
                end else if (mmeas[k]) begin
                    if (pulse_in) begin
                        mwidth[k]++;
                    end else begin
                        done = 1;
                        e = mwidth[k] > MAXW;
                        v = e ? MAXW : mwidth[k];
                        mmeas[k] = 0;
                    end
                end else if (pulse_in && !mprev) begin
                    mmeas[k]  = 1;
                    mwidth[k] = 1;
                end
                keep = done && (e || v >= MINW[k]);
                if (acc) mvalid[k] = 0;
                if (keep) begin
                    if (!mvalid[k]) begin
                        mvalid[k] = 1; mval[k] = v; merr[k] = e;
                    end else begin
                        movr[k] = 1;
                    end
                end
                if (clr_overrun) movr[k] = 0;
            end
            mprev = pulse_in;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("a.valid", int'(if_a.out_valid), int'(mvalid[0]));
        chk("a.overrun", int'(ovr_a), int'(movr[0]));
        if (mvalid[0]) begin
            chk("a.value", int'(if_a.out_value), mval[0]);
            chk("a.err", int'(if_a.out_err), int'(merr[0]));
        end
        chk("b.valid", int'(if_b.out_valid), int'(mvalid[1]));
        chk("b.overrun", int'(ovr_b), int'(movr[1]));
        if (mvalid[1]) begin
            chk("b.value", int'(if_b.out_value), mval[1]);
            chk("b.err", int'(if_b.out_err), int'(merr[1]));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // w high samples, then one low sample that completes the measurement.
    task automatic pulse(input int w);
        pulse_in = 1'b1;
        repeat (w) tick();
        pulse_in = 1'b0;
        tick();
    endtask

    initial begin
        rstn = 1'b0; en = 1'b1; pulse_in = 1'b1; ready = 1'b1; clr_overrun = 1'b0;
        #1;
        chk("rst.valid", int'(if_a.out_valid), 0);
        chk("rst.value", int'(if_a.out_value), 0);
        chk("rst.err", int'(if_a.out_err), 0);
        chk("rst.overrun", int'(ovr_a), 0);
        repeat (2) tick();
        // Release reset with the pulse already high: it must not be decoded.
        rstn = 1'b1;
        repeat (3) tick();
        pulse_in = 1'b0;
        repeat (2) tick();
        chk("partial_rst.valid", int'(if_a.out_valid), 0);

        pulse(4);
        chk("w4.valid", int'(if_a.out_valid), 1);
        chk("w4.value", int'(if_a.out_value), 4);
        tick();

        // Round-trip sweep; valid must appear on the first low-sampling edge.
        for (int d = 1; d <= 15; d++) begin
            pulse(d);
            chk("sweep.valid", int'(if_a.out_valid), 1);
            chk("sweep.value", int'(if_a.out_value), d);
            chk("sweep.err", int'(if_a.out_err), 0);
        end
        tick();

        pulse(20);
        chk("ovf.value", int'(if_a.out_value), 15);
        chk("ovf.err", int'(if_a.out_err), 1);
        tick();

        // Glitch filter on the MIN_WIDTH=3 instance.
        pulse(2);
        chk("glitch2.b_valid", int'(if_b.out_valid), 0);
        chk("glitch2.a_value", int'(if_a.out_value), 2);
        pulse(4);
        chk("glitch4.b_value", int'(if_b.out_value), 4);
        tick();

        // Backpressure and overrun.
        ready = 1'b0;
        pulse(6);
        pulse(9);
        chk("bp.value", int'(if_a.out_value), 6);
        chk("bp.overrun", int'(ovr_a), 1);
        ready = 1'b1;
        tick();
        chk("bp.drained", int'(if_a.out_valid), 0);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("bp.clr", int'(ovr_a), 0);

        // Accept and completion on the same edge.
        ready = 1'b0;
        pulse(3);
        chk("sim.hold", int'(if_a.out_value), 3);
        pulse_in = 1'b1;
        repeat (7) tick();
        pulse_in = 1'b0;
        ready = 1'b1;
        tick();
        chk("sim.value", int'(if_a.out_value), 7);
        chk("sim.valid", int'(if_a.out_valid), 1);
        chk("sim.overrun", int'(ovr_a), 0);
        tick();

        // Enable rising mid-pulse: that pulse is lost.
        en = 1'b0;
        tick();
        pulse_in = 1'b1;
        tick();
        en = 1'b1;
        repeat (3) tick();
        pulse_in = 1'b0;
        tick();
        chk("en_mid.valid", int'(if_a.out_valid), 0);
        pulse(4);
        chk("en_mid.next", int'(if_a.out_value), 4);
        tick();

        // Asynchronous reset while measuring with a full slot and overrun set.
        ready = 1'b0;
        pulse(5);
        pulse(2);
        pulse_in = 1'b1;
        repeat (3) tick();
        #2 rstn = 1'b0;
        #1;
        chk("amid.valid", int'(if_a.out_valid), 0);
        chk("amid.value", int'(if_a.out_value), 0);
        chk("amid.overrun", int'(ovr_a), 0);
        ready = 1'b1;
        tick();
        rstn = 1'b1;
        repeat (2) tick();
        pulse_in = 1'b0;
        tick();
        chk("arel.valid", int'(if_a.out_valid), 0);
        pulse(4);
        chk("arel.value", int'(if_a.out_value), 4);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
